// File: rtl/wb_stage.sv
// wb_stage: M/W pipeline register and write-back data path.
// Latches the M-stage results, extends load data by type and byte offset,
// and selects the value written to the register file in W. The same
// RegWr_W/A3_W/WD_W triple also serves as the W-stage forwarding source.
module wb_stage #(
    parameter logic [31:0] PC_RESET    = 32'h0000_3000,
    parameter logic [31:0] LINK_OFFSET = 32'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_W,
    input  logic        clr_W,
    input  logic [31:0] PC_M,
    input  logic        RegWr_M,
    input  logic [4:0]  A3_M,
    input  logic [1:0]  WDSel_M,
    input  logic [2:0]  LdType_M,
    input  logic [31:0] ALUOut_M,
    input  logic [31:0] DMRD_M,
    output logic        RegWr_W,
    output logic [4:0]  A3_W,
    output logic [31:0] WD_W,
    output logic [31:0] PC_W
);

    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_MEM  = 2'd1;
    localparam logic [1:0] SEL_LINK = 2'd2;

    logic [31:0] pc_q;
    logic        regwr_q;
    logic [4:0]  a3_q;
    logic [1:0]  wdsel_q;
    logic [2:0]  ldtype_q;
    logic [31:0] aluout_q;
    logic [31:0] dmrd_q;

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;

    // Pipeline register: reset and bubble clear everything, stall holds, otherwise latch M.
    always_ff @(posedge clk) begin
        if (!reset || clr_W) begin
            pc_q     <= PC_RESET;
            regwr_q  <= 1'b0;
            a3_q     <= 5'd0;
            wdsel_q  <= 2'd0;
            ldtype_q <= 3'd0;
            aluout_q <= 32'd0;
            dmrd_q   <= 32'd0;
        end else if (!stall_W) begin
            pc_q     <= PC_M;
            regwr_q  <= RegWr_M & (A3_M != 5'd0);
            a3_q     <= A3_M;
            wdsel_q  <= WDSel_M;
            ldtype_q <= LdType_M;
            aluout_q <= ALUOut_M;
            dmrd_q   <= DMRD_M;
        end
    end

    // Pick the addressed byte and halfword out of the aligned memory word.
    always_comb begin
        load_byte = dmrd_q[7:0];
        case (aluout_q[1:0])
            2'd0:    load_byte = dmrd_q[7:0];
            2'd1:    load_byte = dmrd_q[15:8];
            2'd2:    load_byte = dmrd_q[23:16];
            default: load_byte = dmrd_q[31:24];
        endcase
        load_half = aluout_q[1] ? dmrd_q[31:16] : dmrd_q[15:0];
    end

    // Sign- or zero-extend the selected piece according to the load type.
    always_comb begin
        load_ext = dmrd_q;
        case (ldtype_q)
            LD_LB:   load_ext = {{24{load_byte[7]}}, load_byte};
            LD_LBU:  load_ext = {24'd0, load_byte};
            LD_LH:   load_ext = {{16{load_half[15]}}, load_half};
            LD_LHU:  load_ext = {16'd0, load_half};
            default: load_ext = dmrd_q;
        endcase
    end

    // Write-back source select; the link address wraps modulo 2^32.
    always_comb begin
        WD_W = 32'd0;
        case (wdsel_q)
            SEL_ALU:  WD_W = aluout_q;
            SEL_MEM:  WD_W = load_ext;
            SEL_LINK: WD_W = pc_q + LINK_OFFSET;
            default:  WD_W = 32'd0;
        endcase
    end

    assign RegWr_W = regwr_q;
    assign A3_W    = a3_q;
    assign PC_W    = pc_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed bench for wb_stage with a behavioural model of the
// write-back result that is checked every cycle, plus literal expectations.
module tb_wb_stage;

    localparam logic [31:0] PC_RST = 32'h0000_3000;

    logic        clk;
    logic        reset;
    logic        stall_W;
    logic        clr_W;
    logic [31:0] PC_M;
    logic        RegWr_M;
    logic [4:0]  A3_M;
    logic [1:0]  WDSel_M;
    logic [2:0]  LdType_M;
    logic [31:0] ALUOut_M;
    logic [31:0] DMRD_M;
    logic        RegWr_W;
    logic [4:0]  A3_W;
    logic [31:0] WD_W;
    logic [31:0] PC_W;

    int checks   = 0;
    int failures = 0;

    logic        m_valid = 1'b0;
    logic        m_regwr;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic [31:0] m_pc;

    wb_stage dut (
        .clk      (clk),
        .reset    (reset),
        .stall_W  (stall_W),
        .clr_W    (clr_W),
        .PC_M     (PC_M),
        .RegWr_M  (RegWr_M),
        .A3_M     (A3_M),
        .WDSel_M  (WDSel_M),
        .LdType_M (LdType_M),
        .ALUOut_M (ALUOut_M),
        .DMRD_M   (DMRD_M),
        .RegWr_W  (RegWr_W),
        .A3_W     (A3_W),
        .WD_W     (WD_W),
        .PC_W     (PC_W)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-back value an instruction must produce, worked out arithmetically.
    function automatic logic [31:0] expectedWd(input logic [31:0] pc, input logic [1:0] wdsel,
                                               input logic [2:0] ldtype, input logic [31:0] alu,
                                               input logic [31:0] dmrd);
        int unsigned off;
        logic [31:0] b;
        logic [31:0] h;
        off = int'(alu[1:0]);
        b = (dmrd >> (8 * off)) & 32'h0000_00FF;
        h = (dmrd >> (16 * (off / 2))) & 32'h0000_FFFF;
        if (wdsel == 2'd0) return alu;
        if (wdsel == 2'd2) return pc + 32'd8;
        if (wdsel == 2'd3) return 32'd0;
        case (ldtype)
            3'd1:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return h;
            default: return dmrd;
        endcase
    endfunction

    // Model of the W-stage contents, updated on the same edges the DUT sees.
    always @(posedge clk) begin
        if (!reset || clr_W) begin
            m_regwr = 1'b0;
            m_a3    = 5'd0;
            m_wd    = 32'd0;
            m_pc    = PC_RST;
        end else if (!stall_W) begin
            m_regwr = RegWr_M && (A3_M != 5'd0);
            m_a3    = A3_M;
            m_wd    = expectedWd(PC_M, WDSel_M, LdType_M, ALUOut_M, DMRD_M);
            m_pc    = PC_M;
        end
        m_valid = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model_RegWr_W", {31'd0, RegWr_W}, {31'd0, m_regwr});
            checkOutput("model_A3_W", {27'd0, A3_W}, {27'd0, m_a3});
            checkOutput("model_WD_W", WD_W, m_wd);
            checkOutput("model_PC_W", PC_W, m_pc);
        end
    end

    task automatic applyStimulus(input logic [31:0] pc, input logic regwr, input logic [4:0] a3,
                                 input logic [1:0] wdsel, input logic [2:0] ldtype,
                                 input logic [31:0] alu, input logic [31:0] dmrd);
        PC_M     = pc;
        RegWr_M  = regwr;
        A3_M     = a3;
        WDSel_M  = wdsel;
        LdType_M = ldtype;
        ALUOut_M = alu;
        DMRD_M   = dmrd;
    endtask

    task automatic applyRandom();
        applyStimulus($urandom, 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom), $urandom, $urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic checkStage(input string tag, input logic regwr, input logic [4:0] a3,
                              input logic [31:0] wd, input logic [31:0] pc);
        checkOutput({tag, "_RegWr_W"}, {31'd0, RegWr_W}, {31'd0, regwr});
        checkOutput({tag, "_A3_W"}, {27'd0, A3_W}, {27'd0, a3});
        checkOutput({tag, "_WD_W"}, WD_W, wd);
        checkOutput({tag, "_PC_W"}, PC_W, pc);
    endtask

    initial begin
        reset   = 1'b0;
        stall_W = 1'b0;
        clr_W   = 1'b0;
        applyRandom();

        // Reset held for two cycles with random M inputs.
        tick();
        checkStage("reset1", 1'b0, 5'd0, 32'd0, PC_RST);
        applyRandom();
        tick();
        checkStage("reset2", 1'b0, 5'd0, 32'd0, PC_RST);
        reset = 1'b1;

        // Byte loads from the top byte.
        applyStimulus(32'h0000_3004, 1'b1, 5'd8, 2'd1, 3'd1, 32'h0000_1003, 32'h80FF_7F01);
        tick();
        checkStage("lb_off3", 1'b1, 5'd8, 32'hFFFF_FF80, 32'h0000_3004);
        applyStimulus(32'h0000_3008, 1'b1, 5'd8, 2'd1, 3'd2, 32'h0000_1003, 32'h80FF_7F01);
        tick();
        checkStage("lbu_off3", 1'b1, 5'd8, 32'h0000_0080, 32'h0000_3008);
        applyStimulus(32'h0000_300C, 1'b1, 5'd9, 2'd1, 3'd1, 32'h0000_1001, 32'h80FF_7F01);
        tick();
        checkOutput("lb_off1_WD_W", WD_W, 32'h0000_007F);
        applyStimulus(32'h0000_3010, 1'b1, 5'd9, 2'd1, 3'd1, 32'h0000_1002, 32'h80FF_7F01);
        tick();
        checkOutput("lb_off2_WD_W", WD_W, 32'hFFFF_FFFF);

        // Halfword loads; offset bit 0 must not matter.
        applyStimulus(32'h0000_3014, 1'b1, 5'd10, 2'd1, 3'd4, 32'h0000_2002, 32'h8001_1234);
        tick();
        checkOutput("lhu_off2_WD_W", WD_W, 32'h0000_8001);
        applyStimulus(32'h0000_3018, 1'b1, 5'd10, 2'd1, 3'd3, 32'h0000_2002, 32'h8001_1234);
        tick();
        checkOutput("lh_off2_WD_W", WD_W, 32'hFFFF_8001);
        applyStimulus(32'h0000_301C, 1'b1, 5'd10, 2'd1, 3'd4, 32'h0000_2003, 32'h8001_1234);
        tick();
        checkOutput("lhu_off3_WD_W", WD_W, 32'h0000_8001);
        applyStimulus(32'h0000_3020, 1'b1, 5'd10, 2'd1, 3'd3, 32'h0000_2003, 32'h8001_1234);
        tick();
        checkOutput("lh_off3_WD_W", WD_W, 32'hFFFF_8001);
        applyStimulus(32'h0000_3024, 1'b1, 5'd10, 2'd1, 3'd3, 32'h0000_2001, 32'h8001_9234);
        tick();
        checkOutput("lh_off1_WD_W", WD_W, 32'hFFFF_9234);

        // Word loads, including the undefined types that behave like LW.
        applyStimulus(32'h0000_3028, 1'b1, 5'd11, 2'd1, 3'd0, 32'h0000_2003, 32'h8001_1234);
        tick();
        checkOutput("lw_WD_W", WD_W, 32'h8001_1234);
        applyStimulus(32'h0000_302C, 1'b1, 5'd11, 2'd1, 3'd6, 32'h0000_2001, 32'hCAFE_F00D);
        tick();
        checkOutput("ld6_WD_W", WD_W, 32'hCAFE_F00D);

        // Link address wraps past the top of the address space.
        applyStimulus(32'hFFFF_FFFC, 1'b1, 5'd31, 2'd2, 3'd1, 32'h0000_0003, 32'h1111_1111);
        tick();
        checkStage("link_wrap", 1'b1, 5'd31, 32'h0000_0004, 32'hFFFF_FFFC);

        // Reserved select gives zero; ALU select ignores load type.
        applyStimulus(32'h0000_3030, 1'b1, 5'd12, 2'd3, 3'd1, 32'h1234_5678, 32'hFFFF_FFFF);
        tick();
        checkOutput("wdsel3_WD_W", WD_W, 32'h0000_0000);
        applyStimulus(32'h0000_3034, 1'b1, 5'd12, 2'd0, 3'd1, 32'h1234_5679, 32'hFFFF_FFFF);
        tick();
        checkOutput("alu_WD_W", WD_W, 32'h1234_5679);

        // Writes to $0 are suppressed.
        applyStimulus(32'h0000_3038, 1'b1, 5'd0, 2'd0, 3'd0, 32'hDEAD_BEEF, 32'h0);
        tick();
        checkStage("zero_guard", 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h0000_3038);

        // A reset glitch between edges must not disturb the registers.
        applyStimulus(32'h0000_3040, 1'b1, 5'd9, 2'd0, 3'd0, 32'h1234_5678, 32'h0);
        tick();
        #1 reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        checkStage("async_glitch", 1'b1, 5'd9, 32'h1234_5678, 32'h0000_3040);

        // Stall for three cycles while the M inputs keep changing.
        stall_W = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h0000_4000 + 32'(i * 4), 1'b1, 5'(20 + i), 2'd2, 3'd1, 32'hA5A5_0000 + 32'(i), 32'h0);
            tick();
            checkStage($sformatf("stall%0d", i), 1'b1, 5'd9, 32'h1234_5678, 32'h0000_3040);
        end

        // Bubble wins over stall.
        clr_W = 1'b1;
        tick();
        checkStage("clr_over_stall", 1'b0, 5'd0, 32'd0, PC_RST);
        clr_W   = 1'b0;
        stall_W = 1'b0;

        // Reset clears even while stalled.
        applyStimulus(32'h0000_5000, 1'b1, 5'd7, 2'd2, 3'd0, 32'h0, 32'h0);
        tick();
        checkStage("pre_reset", 1'b1, 5'd7, 32'h0000_5008, 32'h0000_5000);
        stall_W = 1'b1;
        reset   = 1'b0;
        tick();
        checkStage("reset_in_stall", 1'b0, 5'd0, 32'd0, PC_RST);
        reset   = 1'b1;
        stall_W = 1'b0;

        // A few random cycles checked only by the model.
        for (int i = 0; i < 20; i++) begin
            applyRandom();
            stall_W = ($urandom_range(0, 4) == 0);
            clr_W   = ($urandom_range(0, 6) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
